// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types and constants for the APB command master
// Holds the transfer state enum, default bus widths and the timeout counter width.
package apb_master_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int TMO_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // PSEL is asserted exactly while a transfer occupies the APB segment.
  function automatic logic bus_selected(input apb_state_e s);
    return (s == SETUP) || (s == ACCESS);
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// rtl/apb_cmd_master_if.sv - command/response port plus APB3 bus bundle
// master = the initiator's view, slave = the environment (requester + responder) view.
interface apb_cmd_master_if #(
  parameter int ADDR_W = apb_master_pkg::DEF_ADDR_W,
  parameter int DATA_W = apb_master_pkg::DEF_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_tmo;

  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

endinterface

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB3 initiator turning single-word commands into SETUP/ACCESS transfers
// Optional ACCESS timeout is built only when APB_CMD_MASTER_TIMEOUT_EN is defined.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            PCLK,
  input  logic            PRESETN,
  apb_cmd_master_if.master bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << TMO_CNT_W) - 1) begin : g_tmo_range
    $error("apb_cmd_master: TIMEOUT_CYCLES out of range");
  end

  apb_state_e        r_state;
  apb_state_e        w_next;

  logic              r_cmd_ready;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_done;
  logic              w_tmo;

  // cmd_ready is only ever high while idle, so it alone qualifies the handshake.
  assign w_accept = bus.cmd_valid & r_cmd_ready;
  assign w_done   = (r_state == ACCESS) & bus.PREADY;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] r_tmo_cnt;
  logic                 r_rsp_tmo;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_tmo_cnt <= '0;
      r_rsp_tmo <= 1'b0;
    end else begin
      if (r_state == SETUP) begin
        r_tmo_cnt <= '0;
      end else if (r_state == ACCESS && !bus.PREADY) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_CNT_W'(1);
      end
      if (w_done) begin
        r_rsp_tmo <= 1'b0;
      end else if (w_tmo) begin
        r_rsp_tmo <= 1'b1;
      end
    end
  end

  // A PREADY arriving on the limit cycle takes priority over the abort.
  assign w_tmo       = (r_state == ACCESS) && !bus.PREADY &&
                       (r_tmo_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.rsp_tmo = r_rsp_tmo;
`else
  assign w_tmo       = 1'b0;
  assign bus.rsp_tmo = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (w_done || w_tmo) w_next = RESP;
      RESP:    if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state   <= IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_psel    <= bus_selected(w_next);
      r_penable <= (w_next == ACCESS);
    end
  end

  // Ready re-arms one cycle after returning to IDLE, giving a five-cycle minimum period.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_cmd_ready <= 1'b0;
    end else begin
      r_cmd_ready <= (r_state == IDLE) & ~w_accept;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_paddr  <= bus.cmd_addr;
      r_pwrite <= bus.cmd_write;
      r_pwdata <= bus.cmd_wdata;
    end
  end

  // PRDATA/PSLVERR matter only on the completing ACCESS cycle.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= (w_next == RESP);
      if (w_done) begin
        r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
        r_rsp_err   <= bus.PSLVERR;
      end else if (w_tmo) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.PADDR     = r_paddr;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PWDATA    = r_pwdata;

endmodule
